// File: rtl/cla_digit_serial_adder.sv
// Digit-serial adder: one DIGIT-wide carry-lookahead slice per cycle, carry held between digits.
// Optional subtract mode via CLA_DIGIT_SERIAL_SUB_EN (adds io_sub port).
module cla_digit_serial_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_a,
  input  logic [WIDTH-1:0] io_b,
  input  logic             io_c_in,
`ifdef CLA_DIGIT_SERIAL_SUB_EN
  input  logic             io_sub,
`endif
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_sum,
  output logic             io_c_out
);

  localparam int unsigned NDIG  = WIDTH / DIGIT;
  localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic               carry_q, carry_d, c_out_q, c_out_d;

  logic [WIDTH-1:0]   b_in;
  logic               c_in_eff;
  logic [DIGIT-1:0]   ad, bd, p, g, sum_dig;
  logic [DIGIT:0]     c;

  // Subtraction is a + ~b + 1, so only the operand and initial carry change.
`ifdef CLA_DIGIT_SERIAL_SUB_EN
  assign b_in     = io_sub ? ~io_b : io_b;
  assign c_in_eff = io_sub ? 1'b1 : io_c_in;
`else
  assign b_in     = io_b;
  assign c_in_eff = io_c_in;
`endif

  always_comb begin
    ad   = a_q[idx_q*DIGIT +: DIGIT];
    bd   = b_q[idx_q*DIGIT +: DIGIT];
    p    = ad ^ bd;
    g    = ad & bd;
    c    = '0;
    c[0] = carry_q;
    for (int i = 0; i < int'(DIGIT); i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum_dig = p ^ c[DIGIT-1:0];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    case (state_q)
      StIdle: begin
        if (io_in_valid) begin
          a_d     = io_a;
          b_d     = b_in;
          carry_d = c_in_eff;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[idx_q*DIGIT +: DIGIT] = sum_dig;
        carry_d                     = c[DIGIT];
        if (idx_q == IDX_W'(NDIG - 1)) begin
          c_out_d = c[DIGIT];
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (io_out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
    end
  end

  assign io_in_ready  = (state_q == StIdle);
  assign io_out_valid = (state_q == StDone);
  assign io_sum       = sum_q;
  assign io_c_out     = c_out_q;

endmodule

// File: tb/tb_cla_digit_serial_adder.sv
// Scoreboard bench for cla_digit_serial_adder: expected results queued on accept,
// popped by a monitor on each output handshake. Subtract tests need CLA_DIGIT_SERIAL_SUB_EN.
module tb_cla_digit_serial_adder;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DIGIT = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             io_in_valid;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_a;
  logic [WIDTH-1:0] io_b;
  logic             io_c_in;
`ifdef CLA_DIGIT_SERIAL_SUB_EN
  logic             io_sub;
`endif
  logic             io_out_valid;
  logic             io_out_ready;
  logic [WIDTH-1:0] io_sum;
  logic             io_c_out;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [WIDTH:0] exp_q[$];

  cla_digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_a         (io_a),
    .io_b         (io_b),
    .io_c_in      (io_c_in),
`ifdef CLA_DIGIT_SERIAL_SUB_EN
    .io_sub       (io_sub),
`endif
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_sum       (io_sum),
    .io_c_out     (io_c_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain (WIDTH+1)-bit arithmetic.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic cin, input logic sub);
    logic [WIDTH:0] r;
    if (sub) r = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    else     r = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
    return r;
  endfunction

  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub);
    bit done = 0;
    io_in_valid = 1'b1;
    io_a        = a;
    io_b        = b;
    io_c_in     = cin;
`ifdef CLA_DIGIT_SERIAL_SUB_EN
    io_sub      = sub;
`endif
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clock);
      if (io_in_ready) begin
        @(posedge clock);
        exp_q.push_back(model(a, b, cin, sub));
        done = 1;
      end
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    #1 io_in_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd_ready);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
      @(posedge clock);
      #1 io_out_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    io_out_ready = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // Monitor: compare on every accepted output.
  always @(negedge clock) begin
    if (!reset && io_out_valid && io_out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        logic [WIDTH:0] e;
        e = exp_q.pop_front();
        check("sum", 32'(io_sum), 32'(e[WIDTH-1:0]));
        check("c_out", 32'(io_c_out), 32'(e[WIDTH]));
      end
    end
  end

  initial begin
    logic [WIDTH:0] e1;
    bit             seen;
    reset        = 1'b1;
    io_in_valid  = 1'b0;
    io_out_ready = 1'b1;
    io_a         = '0;
    io_b         = '0;
    io_c_in      = 1'b0;
`ifdef CLA_DIGIT_SERIAL_SUB_EN
    io_sub       = 1'b0;
`endif
    #2;
    check("rst_in_ready", 32'(io_in_ready), 32'd1);
    check("rst_out_valid", 32'(io_out_valid), 32'd0);
    check("rst_sum", 32'(io_sum), 32'd0);
    check("rst_c_out", 32'(io_c_out), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Basic add with latency: valid first at the 5th falling edge after accept.
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      check($sformatf("latency_valid_%0d", k), 32'(io_out_valid), (k == 5) ? 32'd1 : 32'd0);
    end
    drain(0);

    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0); drain(0);
    do_op(16'h0000, 16'h0000, 1'b1, 1'b0); drain(0);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0); drain(0);

    // Backpressure in DONE with new operands presented.
    io_out_ready = 1'b0;
    do_op(16'h8001, 16'h7FFF, 1'b0, 1'b0);
    e1          = model(16'h8001, 16'h7FFF, 1'b0, 1'b0);
    io_in_valid = 1'b1;
    io_a        = 16'hAAAA;
    io_b        = 16'h5555;
    io_c_in     = 1'b1;
    seen        = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      seen = io_out_valid;
    end
    check("bp_valid_seen", 32'(seen), 32'd1);
    for (int k = 0; k < 3; k++) begin
      check("bp_sum_hold", 32'(io_sum), 32'(e1[WIDTH-1:0]));
      check("bp_c_out_hold", 32'(io_c_out), 32'(e1[WIDTH]));
      check("bp_in_ready", 32'(io_in_ready), 32'd0);
      check("bp_out_valid", 32'(io_out_valid), 32'd1);
      @(negedge clock);
    end
    @(posedge clock);
    #1 io_out_ready = 1'b1;
    do_op(16'hAAAA, 16'h5555, 1'b1, 1'b0);
    drain(0);

    // Reset mid-RUN at idx=2.
    do_op(16'h0F0F, 16'h0101, 1'b1, 1'b0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("midrst_out_valid", 32'(io_out_valid), 32'd0);
    check("midrst_sum", 32'(io_sum), 32'd0);
    check("midrst_c_out", 32'(io_c_out), 32'd0);
    check("midrst_in_ready", 32'(io_in_ready), 32'd1);
    exp_q.delete();
    @(posedge clock);
    #1 reset = 1'b0;
    do_op(16'h0F0F, 16'h0101, 1'b1, 1'b0);
    drain(0);

`ifdef CLA_DIGIT_SERIAL_SUB_EN
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1); drain(0);
    do_op(16'h0007, 16'h0005, 1'b1, 1'b1); drain(0);
`endif

    for (int n = 0; n < 40; n++) begin
      logic sub;
`ifdef CLA_DIGIT_SERIAL_SUB_EN
      sub = 1'($urandom % 2);
`else
      sub = 1'b0;
`endif
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom % 2), sub);
      drain(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
